// File: rtl/i2c_arbiter.sv
// Two-requester round-robin front end for a single I2C master.
// Latches the winning operands, hands them to the master, and returns the result or a watchdog timeout.
module i2c_arbiter #(
  parameter int TIMEOUT_W = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [6:0] addr0,
  input  logic       rw0,
  input  logic [7:0] wdata0,
  output logic [7:0] rdata0,
  output logic       done0,
  output logic       err0,
  input  logic       req1,
  input  logic [6:0] addr1,
  input  logic       rw1,
  input  logic [7:0] wdata1,
  output logic [7:0] rdata1,
  output logic       done1,
  output logic       err1,
  output logic       m_start,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_data_in,
  input  logic [7:0] m_data_out,
  input  logic       m_busy,
  output logic       owner,
  output logic       active
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  localparam logic [TIMEOUT_W-1:0] WD_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WD_MAX = {TIMEOUT_W{1'b1}};

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 owner_q, owner_d;
  logic                 err_q, err_d;
  logic                 m_start_q, m_start_d;
  logic [6:0]           m_addr_q, m_addr_d;
  logic                 m_rw_q, m_rw_d;
  logic [7:0]           m_data_in_q, m_data_in_d;
  logic [7:0]           rdata0_q, rdata0_d;
  logic [7:0]           rdata1_q, rdata1_d;

  logic [TIMEOUT_W-1:0] wd_inc;
  logic                 expired;
  logic                 pick;

  // Saturating watchdog; the transition fires on the edge that would reach all-ones,
  // so a waiting state lasts exactly 2^TIMEOUT_W-1 cycles.
  assign wd_inc  = (wd_q == WD_MAX) ? wd_q : wd_q + WD_ONE;
  assign expired = (wd_inc == WD_MAX);
  // Contention goes to whoever was not granted last; a lone request always wins.
  assign pick    = (req0 && req1) ? ~owner_q : req1;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: every flop here uses <= so all registers update from the same pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      owner_q     <= 1'b1;
      err_q       <= 1'b0;
      m_start_q   <= 1'b0;
      m_addr_q    <= '0;
      m_rw_q      <= 1'b0;
      m_data_in_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      m_start_q   <= m_start_d;
      m_addr_q    <= m_addr_d;
      m_rw_q      <= m_rw_d;
      m_data_in_q <= m_data_in_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: hold-value defaults first, so no path through the case leaves a signal unassigned (no latches).
    state_d     = state_q;
    wd_d        = wd_q;
    owner_d     = owner_q;
    err_d       = err_q;
    m_addr_d    = m_addr_q;
    m_rw_d      = m_rw_q;
    m_data_in_d = m_data_in_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (!m_busy && (req0 || req1)) begin
          state_d     = START;
          owner_d     = pick;
          wd_d        = '0;
          err_d       = 1'b0;
          m_addr_d    = pick ? addr1  : addr0;
          m_rw_d      = pick ? rw1    : rw0;
          m_data_in_d = pick ? wdata1 : wdata0;
        end
      end
      START: begin
        if (m_busy) begin
          state_d = WAIT;
          wd_d    = '0;
        end else if (expired) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end
      WAIT: begin
        if (!m_busy) begin
          state_d = DONE;
          err_d   = 1'b0;
          if (owner_q) rdata1_d = m_data_out;
          else         rdata0_d = m_data_out;
        end else if (expired) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    m_start_d = (state_d == START);
  end

  // Output logic
  always_comb begin
    active = (state_q != IDLE);
    done0  = (state_q == DONE) && !owner_q;
    done1  = (state_q == DONE) &&  owner_q;
    err0   = done0 && err_q;
    err1   = done1 && err_q;
  end

  assign m_start   = m_start_q;
  assign m_addr    = m_addr_q;
  assign m_rw      = m_rw_q;
  assign m_data_in = m_data_in_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: table-driven transactions against a behavioural master,
// scoreboard queues for grants and completions, plus hand-written corner sequences.
module tb_i2c_arbiter;

  typedef struct {
    bit         who;
    logic [6:0] addr;
    bit         rw;
    logic [7:0] wdata;
    logic [7:0] ret;
    int         delay;
    int         len;
    bit         drop_early;
  } vec_t;

  typedef struct {
    bit         who;
    logic [6:0] addr;
    bit         rw;
    logic [7:0] wdata;
  } start_t;

  typedef struct {
    bit         who;
    bit         err;
    logic [7:0] rdata;
    logic [6:0] addr;
  } done_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
  logic [6:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic [7:0] rdata0, rdata1;
  logic       done0, err0, done1, err1;
  logic       m_start, m_rw, owner, active;
  logic [6:0] m_addr;
  logic [7:0] m_data_in;
  logic [7:0] m_data_out = '0;
  logic       mdl_busy = 1'b0, force_busy = 1'b0;
  logic       m_busy;

  // Second instance with a short watchdog, driven directly by the test.
  logic       t_req0 = 1'b0, t_busy = 1'b0;
  logic [7:0] t_data_out = '0;
  logic [7:0] t_rdata0, t_rdata1, t_m_data_in;
  logic       t_done0, t_err0, t_done1, t_err1, t_m_start, t_m_rw, t_owner, t_active;
  logic [6:0] t_m_addr;

  int         mdl_delay = 0, mdl_len = 1;
  logic [7:0] mdl_ret = '0;
  logic [7:0] exp_rdata [2];

  start_t start_q[$];
  done_t  done_q[$];
  int     n_checks = 0;
  int     n_fail = 0;

  assign m_busy = mdl_busy | force_busy;

  always #5 clk = ~clk;

  i2c_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .rw0(rw0), .wdata0(wdata0),
    .rdata0(rdata0), .done0(done0), .err0(err0),
    .req1(req1), .addr1(addr1), .rw1(rw1), .wdata1(wdata1),
    .rdata1(rdata1), .done1(done1), .err1(err1),
    .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_data_in(m_data_in),
    .m_data_out(m_data_out), .m_busy(m_busy), .owner(owner), .active(active)
  );

  i2c_arbiter #(.TIMEOUT_W(4)) dut_t (
    .clk(clk), .reset(reset),
    .req0(t_req0), .addr0(7'h10), .rw0(1'b1), .wdata0(8'h00),
    .rdata0(t_rdata0), .done0(t_done0), .err0(t_err0),
    .req1(1'b0), .addr1(7'h00), .rw1(1'b0), .wdata1(8'h00),
    .rdata1(t_rdata1), .done1(t_done1), .err1(t_err1),
    .m_start(t_m_start), .m_addr(t_m_addr), .m_rw(t_m_rw), .m_data_in(t_m_data_in),
    .m_data_out(t_data_out), .m_busy(t_busy), .owner(t_owner), .active(t_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Behavioural master: raises busy mdl_delay cycles into START, holds it mdl_len cycles.
  initial begin : master
    forever begin
      @(negedge clk);
      if (m_start && !mdl_busy && !reset) begin
        repeat (mdl_delay) @(negedge clk);
        mdl_busy = 1'b1;
        repeat (mdl_len) @(negedge clk);
        m_data_out = mdl_ret;
        mdl_busy   = 1'b0;
      end
    end
  end

  // Scoreboard: grants checked on m_start rise, completions on each done pulse.
  initial begin : monitor
    logic   prev;
    start_t s;
    done_t  d;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (m_start && !prev) begin
          if (start_q.size() == 0) fail_now("unexpected_start");
          else begin
            s = start_q.pop_front();
            check("grant_owner", owner, s.who);
            check("grant_m_addr", m_addr, s.addr);
            check("grant_m_rw", m_rw, s.rw);
            check("grant_m_data_in", m_data_in, s.wdata);
          end
        end
        prev = m_start;
        if (done0 || done1) begin
          if (done_q.size() == 0) fail_now("unexpected_done");
          else begin
            d = done_q.pop_front();
            check("done_both_low", done0 & done1, 1'b0);
            check("done_who", done1, d.who);
            check("done_err", d.who ? err1 : err0, d.err);
            check("done_other_err", d.who ? err0 : err1, 1'b0);
            check("done_rdata", d.who ? rdata1 : rdata0, d.rdata);
            check("done_m_addr_held", m_addr, d.addr);
            exp_rdata[d.who] = d.rdata;
            check("done_other_rdata", d.who ? rdata0 : rdata1, exp_rdata[!d.who]);
          end
        end
      end
    end
  end

  task automatic drive(input bit who, input logic [6:0] a, input bit rw, input logic [7:0] wd,
                       input bit rq);
    if (who) begin addr1 = a; rw1 = rw; wdata1 = wd; req1 = rq; end
    else     begin addr0 = a; rw0 = rw; wdata0 = wd; req0 = rq; end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_start) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("start_timeout");
  endtask

  task automatic wait_done(input bit who, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (who ? done1 : done0) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("done_timeout");
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int cnt;
    mdl_delay = v.delay;
    mdl_len   = v.len;
    mdl_ret   = v.ret;
    start_q.push_back('{v.who, v.addr, v.rw, v.wdata});
    done_q.push_back('{v.who, 1'b0, v.ret, v.addr});
    drive(v.who, v.addr, v.rw, v.wdata, 1'b1);
    wait_start(ok);
    // Scramble the requester's operands mid-flight; the latched copy must not move.
    drive(v.who, ~v.addr, ~v.rw, ~v.wdata, !v.drop_early);
    cnt = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!m_start) break;
      cnt++;
    end
    check("m_start_len", cnt, v.delay + 1);
    wait_done(v.who, ok);
    drive(v.who, ~v.addr, ~v.rw, ~v.wdata, 1'b0);
    @(negedge clk);
  endtask

  initial begin : test
    vec_t vecs [5];
    bit   ok;
    int   cnt;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    vecs[0] = '{1'b0, 7'h48, 1'b0, 8'hA5, 8'h11, 5, 40, 1'b0};
    vecs[1] = '{1'b1, 7'h22, 1'b1, 8'h00, 8'h3C, 3, 10, 1'b0};
    vecs[2] = '{1'b0, 7'h7F, 1'b1, 8'hFF, 8'hC3, 0, 1,  1'b1};
    vecs[3] = '{1'b1, 7'h00, 1'b0, 8'h5A, 8'h96, 2, 4,  1'b0};
    vecs[4] = '{1'b1, 7'h55, 1'b1, 8'h01, 8'h7E, 1, 2,  1'b1};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_m_start", m_start, 1'b0);
    check("rst_m_addr", m_addr, 7'h00);
    check("rst_m_rw", m_rw, 1'b0);
    check("rst_m_data_in", m_data_in, 8'h00);
    check("rst_rdata0", rdata0, 8'h00);
    check("rst_rdata1", rdata1, 8'h00);
    check("rst_done_err", {done0, err0, done1, err1}, 4'b0000);
    check("rst_active", active, 1'b0);
    check("rst_owner", owner, 1'b1);
    check("rst_t_owner", t_owner, 1'b1);
    reset = 1'b0;

    // Simultaneous requests from reset: 0 first, 1 in the IDLE cycle after DONE, then 0 again.
    mdl_delay = 1; mdl_len = 3; mdl_ret = 8'h21;
    for (int round = 0; round < 2; round++) begin
      start_q.push_back('{1'b0, 7'h31, 1'b0, 8'h0A});
      start_q.push_back('{1'b1, 7'h32, 1'b1, 8'h0B});
      done_q.push_back('{1'b0, 1'b0, 8'h21, 7'h31});
      done_q.push_back('{1'b1, 1'b0, 8'h21, 7'h32});
      drive(1'b0, 7'h31, 1'b0, 8'h0A, 1'b1);
      drive(1'b1, 7'h32, 1'b1, 8'h0B, 1'b1);
      wait_done(1'b0, ok);
      req0 = 1'b0;
      @(negedge clk);
      check("rr_gap_idle", active, 1'b0);
      @(negedge clk);
      check("rr_second_start", {m_start, owner}, 2'b11);
      wait_done(1'b1, ok);
      req1 = 1'b0;
      @(negedge clk);
    end

    // Table-driven single transactions
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Busy master blocks IDLE; START follows on the edge after busy drops.
    force_busy = 1'b1;
    mdl_delay = 2; mdl_len = 3; mdl_ret = 8'h6B;
    start_q.push_back('{1'b0, 7'h33, 1'b1, 8'h44});
    done_q.push_back('{1'b0, 1'b0, 8'h6B, 7'h33});
    drive(1'b0, 7'h33, 1'b1, 8'h44, 1'b1);
    repeat (4) @(negedge clk);
    check("busy_hold_active", active, 1'b0);
    check("busy_hold_m_start", m_start, 1'b0);
    force_busy = 1'b0;
    @(negedge clk);
    check("busy_release_start", m_start, 1'b1);
    wait_done(1'b0, ok);
    req0 = 1'b0;
    @(negedge clk);

    // Reset during WAIT aborts silently.
    mdl_delay = 1; mdl_len = 30; mdl_ret = 8'hD2;
    start_q.push_back('{1'b0, 7'h0F, 1'b0, 8'h99});
    drive(1'b0, 7'h0F, 1'b0, 8'h99, 1'b1);
    wait_start(ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (active && !m_start) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("wait_state_timeout");
    reset = 1'b1;
    req0  = 1'b0;
    @(negedge clk);
    check("abort_active", active, 1'b0);
    check("abort_m_start", m_start, 1'b0);
    check("abort_owner", owner, 1'b1);
    check("abort_done", {done0, done1}, 2'b00);
    reset = 1'b0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    repeat (40) @(negedge clk);
    check("sb_start_drained", start_q.size(), 0);
    check("sb_done_drained", done_q.size(), 0);

    // Short-watchdog instance: a good read first so rdata0 has a known non-reset value.
    t_req0 = 1'b1;
    for (int i = 0; i < 20 && !t_m_start; i++) @(negedge clk);
    t_busy = 1'b1;
    repeat (3) @(negedge clk);
    t_data_out = 8'h5A;
    t_busy     = 1'b0;
    for (int i = 0; i < 20 && !t_done0; i++) @(negedge clk);
    check("t_ok_done_err", {t_done0, t_err0}, 2'b10);
    check("t_ok_rdata0", t_rdata0, 8'h5A);
    t_req0 = 1'b0;
    @(negedge clk);

    // START timeout: busy never rises.
    t_data_out = 8'hEE;
    t_req0 = 1'b1;
    for (int i = 0; i < 20 && !t_m_start; i++) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 100 && t_m_start; i++) begin
      cnt++;
      @(negedge clk);
    end
    check("t_start_to_len", cnt, 15);
    check("t_start_to_done_err", {t_done0, t_err0, t_done1, t_err1}, 4'b1100);
    check("t_start_to_rdata0", t_rdata0, 8'h5A);
    t_req0 = 1'b0;
    @(negedge clk);

    // WAIT timeout: busy rises and never falls.
    t_req0 = 1'b1;
    for (int i = 0; i < 20 && !t_m_start; i++) @(negedge clk);
    t_busy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100 && !t_done0; i++) begin
      cnt++;
      @(negedge clk);
    end
    check("t_wait_to_len", cnt, 16);
    check("t_wait_to_done_err", {t_done0, t_err0}, 2'b11);
    check("t_wait_to_rdata0", t_rdata0, 8'h5A);
    t_req0 = 1'b0;
    t_busy = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter TIMEOUT_W, default 20: width of the watchdog counter; timeout fires after 2^TIMEOUT_W-1 cycles in a waiting state.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 transaction request, level, held until done0.
REQ-005 addr0  input  7  requester 0 slave address.
REQ-006 rw0  input  1  requester 0 direction (0 write, 1 read).
REQ-007 wdata0  input  8  requester 0 write byte.
REQ-008 rdata0  output  8  requester 0 read byte, valid with done0.
REQ-009 done0  output  1  one-cycle pulse, requester 0 transaction finished.
REQ-010 err0  output  1  timeout flag, valid only with done0.
REQ-011 req1, addr1, rw1, wdata1, rdata1, done1, err1: same directions, widths and meanings as REQ-004..REQ-010, for requester 1.
REQ-012 m_start  output  1  drives the master's startTask.
REQ-013 m_addr  output  7  drives the master's addr.
REQ-014 m_rw  output  1  drives the master's rw.
REQ-015 m_data_in  output  8  drives the master's data_in.
REQ-016 m_data_out  input  8  the master's data_out.
REQ-017 m_busy  input  1  the master's busy.
REQ-018 owner  output  1  index of the requester currently or last granted.
REQ-019 active  output  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, START, WAIT and DONE.
REQ-021 In IDLE with m_busy=0 and at least one req high, the next edge SHALL enter START, latch the winner's addr/rw/wdata into m_addr/m_rw/m_data_in, set owner, and clear the watchdog.
REQ-022 Arbitration SHALL be round-robin: single request wins; on simultaneous requests the requester not equal to last owner wins.
REQ-023 IDLE SHALL NOT leave while m_busy=1, regardless of requests.
REQ-024 m_start SHALL be a registered output, high exactly while in START.
REQ-025 START→WAIT on the first edge where m_busy=1, clearing the watchdog. m_start is held because the master samples it only on its own SCL strobe.
REQ-026 START→DONE with err set on watchdog expiry while m_busy stays 0.
REQ-027 WAIT→DONE on the first edge where m_busy=0, capturing m_data_out into the owner's rdata (read or write) with err clear.
REQ-028 WAIT→DONE with err set on watchdog expiry while m_busy stays 1. rdata SHALL be unchanged on any error.
REQ-029 In DONE, the owner's done and err SHALL be driven for exactly one cycle. The non-owner's done/err SHALL stay 0. The next state SHALL be IDLE.
REQ-030 Watchdog: TIMEOUT_W-bit counter, increments each cycle in START/WAIT, saturates at all-ones, and expiry is detected at all-ones.
REQ-031 Operand latches SHALL be stable from START entry to DONE exit. Requester input changes during a transaction SHALL be ignored.
REQ-032 A requester dropping req mid-transaction SHALL NOT abort it; done still pulses.
REQ-033 A req still high in the IDLE cycle after DONE SHALL be treated as a new request. Requesters drop req on seeing done.
REQ-034 Minimum grant-to-grant spacing SHALL be 4 cycles (IDLE, START, WAIT, DONE).

Reset
REQ-035 While reset=1, the block SHALL enter IDLE on the next edge.
REQ-036 Reset values: m_start=0, m_addr=0, m_rw=0, m_data_in=0, rdata0=rdata1=0, done0/1=0, err0/1=0, active=0, owner=1, watchdog=0.
REQ-037 Reset mid-transaction SHALL abort silently: no done pulse, and m_start deasserted on the next edge.

Verification
REQ-038 req0=1, addr0=0x48, rw0=0, wdata0=0xA5; master model raises busy 5 cycles after m_start and drops it 40 cycles later -> m_addr=0x48, m_data_in=0xA5, m_start high until busy, one done0 pulse, err0=0, owner=0.
REQ-039 req0 and req1 both high from reset -> requester 0 served first. Requester 1 starts in the IDLE cycle after DONE. A third simultaneous request after that goes to requester 0.
REQ-040 req1=1, rw1=1; model returns m_data_out=0x3C at busy fall -> rdata1=0x3C with done1. rdata0 unchanged.
REQ-041 TIMEOUT_W=4, busy never rises -> m_start high 15 cycles, then done0=1 and err0=1 together. rdata0 unchanged.
REQ-042 m_busy=1 at idle with req0=1 -> stays IDLE, m_start=0. After busy drops, START follows next edge.
REQ-043 Reset asserted during WAIT -> next edge: IDLE, m_start=0, no done pulse, owner=1.
